// File: rtl/lifo_arb_pkg.sv
// Shared constants and width helpers for the shared-stack arbiter.
// Imported by the interface, the round-robin arbiter and the top.
package lifo_arb_pkg;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // Requester-ID width; a single requester still needs one bit.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Level must hold 0..DEPTH inclusive, hence the extra bit.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Client-side bundle of the shared-stack arbiter.
// Clients drive requests through master; the arbiter answers through slave.
interface lifo_arbiter_if
    import lifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8
);
    localparam int ID_W  = id_w(NUM_REQ);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        op;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic                      flush;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic [LVL_W-1:0]          level;
    logic                      full;
    logic                      empty;

    modport master (
        output req, op, wdata, flush,
        input  gnt, rsp_valid, rsp_id, rsp_data, level, full, empty
    );

    modport slave (
        input  req, op, wdata, flush,
        output gnt, rsp_valid, rsp_id, rsp_data, level, full, empty
    );

endinterface

// File: rtl/lifo_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module lifo_rr_arbiter
    import lifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_gnt
);
    localparam int SUM_W = ID_W + 1;

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_elig;

    // Candidate k is the requester k positions past the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum = SUM_W'(rr_ptr) + SUM_W'(gi);
        assign cand_idx[gi]  = (sum >= SUM_W'(NUM_REQ)) ? ID_W'(sum - SUM_W'(NUM_REQ))
                                                        : ID_W'(sum);
        assign cand_elig[gi] = eligible[cand_idx[gi]];
    end

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_elig[k]) begin
                gnt_idx = cand_idx[k];
                any_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shared-stack controller: round-robin push/pop arbitration onto one LIFO,
// with level tracking, full/empty status, flush and tagged pop responses.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    lifo_arbiter_if.slave  bus
);
    localparam int ID_W   = id_w(NUM_REQ);
    localparam int LVL_W  = lvl_w(DEPTH);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LVL_W-1:0]  level_q, level_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic               full, empty;
    logic [NUM_REQ-1:0] eligible, gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_gnt, push_en, pop_en;
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [DATA_W-1:0]  wsel;
    logic [ADDR_W-1:0]  wr_idx, rd_idx;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Reset and flush suppress every grant so nothing executes in those cycles.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign eligible[gi]  = bus.req[gi] & ~bus.flush & ~reset &
                               ((bus.op[gi] == OP_PUSH) ? ~full : ~empty);
        assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

    lifo_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .any_gnt  (any_gnt)
    );

    assign push_en = any_gnt & (bus.op[gnt_idx] == OP_PUSH);
    assign pop_en  = any_gnt & (bus.op[gnt_idx] == OP_POP);
    assign wsel    = wdata_arr[gnt_idx];
    // Indices are only meaningful under the full/empty eligibility guards.
    assign wr_idx  = level_q[ADDR_W-1:0];
    assign rd_idx  = ADDR_W'(level_q - LVL_W'(1));

    always_comb begin
        level_d     = level_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (bus.flush) begin
            level_d = '0;
        end else if (push_en) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_en) begin
            level_d     = level_q - LVL_W'(1);
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_data_d  = mem[rd_idx];
        end
        if (any_gnt) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            level_q     <= level_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_idx] <= wsel;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.level     = level_q;
    assign bus.full      = full;
    assign bus.empty     = empty;

endmodule
